maze_row_fetch_arbiter: RTL and testbench
=========================================

MAZE_ROW_FETCH_ARBITER -- requirements
Module: maze_row_fetch_arbiter

Interface
REQ-001 SHALL have parameter MAX_W, default 20: maximum maze width in cells and row_buf width.
REQ-002 SHALL have parameter MAX_H, default 20: maximum maze height in cells.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port frame_start  input  1  one-cycle pulse at the first line of each frame.
REQ-006 SHALL have port line_start  input  1  one-cycle pulse at the start of horizontal blanking of each line.
REQ-007 SHALL have port maze_width  input  5  cells per row; legal range 1..MAX_W.
REQ-008 SHALL have port maze_height  input  5  rows per maze; legal range 1..MAX_H.
REQ-009 SHALL have port tile_shift  input  3  log2 of tile height in lines.
REQ-010 SHALL have port gen_req  input  1  maze-generator access request; held until granted.
REQ-011 SHALL have port gen_we  input  1  generator write (1) / read (0).
REQ-012 SHALL have port gen_addr  input  10  generator address {row[4:0], col[4:0]}.
REQ-013 SHALL have port gen_wdata  input  1  generator write data (1 = path).
REQ-014 SHALL have port gen_gnt  output  1  one-cycle pulse: generator access issued this cycle.
REQ-015 SHALL have port gen_rdata  output  1  mem_rdata registered for the generator, valid the cycle after gen_gnt+1.
REQ-016 SHALL have ports mem_addr  output  10, mem_we  output  1, mem_wdata  output  1: shared single-port maze RAM.
REQ-017 SHALL have port mem_rdata  input  1  RAM read data, one-cycle read latency.
REQ-018 SHALL have port row_buf  output  MAX_W  path bits of the current tile row; bit c = cell column c.
REQ-019 SHALL have port row_valid  output  1  one-cycle pulse when row_buf updates.
REQ-020 SHALL have port fetch_busy  output  1  high in FETCH or DRAIN.
REQ-021 SHALL have port overrun  output  1  sticky: line_start arrived while fetch_busy; cleared by frame_start.
REQ-022 SHALL have port cfg_err  output  1  high while maze_width or maze_height is 0 or beyond its MAX.

Function
REQ-023 SHALL hold line counter lc (10 bits) and tile row tr (5 bits); frame_start sets lc=0, tr=0.
REQ-024 SHALL, on line_start, increment lc; when (lc & ((1<<tile_shift)-1))==0, a row boundary occurs for tr, then tr increments after the fetch is queued.
REQ-025 SHALL, at a row boundary with tr<maze_height and cfg_err=0, set fetch_pending; otherwise clear row_buf to 0 and pulse row_valid the next cycle.
REQ-026 SHALL implement FSM IDLE, FETCH, DRAIN; IDLE->FETCH when fetch_pending, same cycle preempting any gen_req.
REQ-027 SHALL in FETCH issue mem reads addr {tr,col} for col=0..maze_width-1, one per cycle, mem_we=0; after col=maze_width-1 go to DRAIN.
REQ-028 SHALL capture mem_rdata into a shadow register bit col-1 each cycle after a read issue; DRAIN captures the last bit and returns to IDLE.
REQ-029 SHALL copy shadow to row_buf and pulse row_valid on the DRAIN->IDLE edge; total latency maze_width+2 cycles from line_start; bits >= maze_width are 0.
REQ-030 SHALL grant the generator only in IDLE with no fetch_pending: drive mem_* from gen_*, pulse gen_gnt, at most one access per cycle.
REQ-031 SHALL never grant the generator in FETCH or DRAIN; gen_req waits without loss.
REQ-032 SHALL, on line_start while fetch_busy, set overrun, not restart the fetch, still update lc/tr.
REQ-033 SHALL, on frame_start while fetch_busy, abort to IDLE without updating row_buf, clear overrun, clear fetch_pending.
REQ-034 SHALL drive mem_we=0 and mem_addr=0 when no access is issued.

Reset
REQ-035 SHALL on reset asynchronously set FSM=IDLE, lc=0, tr=0, fetch_pending=0, row_buf=0, shadow=0, and all outputs 0.
REQ-036 SHALL on reset deassertion mid-fetch resume at IDLE with no partial row_buf update.

Verification
REQ-037 SHALL verify: width=4, RAM row0=1011b (col0=1), frame_start then line_start -> row_valid 6 cycles later, row_buf=0x0D.
REQ-038 SHALL verify: gen_req write addr {3,2}=1 during FETCH -> gen_gnt delayed until IDLE, then one pulse, mem_we=1 addr=0x062.
REQ-039 SHALL verify: tile_shift=2 -> fetches only on lines 0,4,8,...; tr increments 0,1,2.
REQ-040 SHALL verify: width=20, line_start 10 cycles after previous -> overrun=1, held until frame_start.
REQ-041 SHALL verify: height=2, third row boundary -> no RAM reads, row_buf=0, row_valid pulses.
REQ-042 SHALL verify: reset asserted mid-FETCH -> all outputs 0 immediately, no row_valid afterwards until next line_start.

Source files
------------

// File: rtl/maze_row_fetch_arbiter.sv
// Maze row fetch arbiter.
// Shares one single-port maze RAM between the video path and the maze generator.
// At each tile-row boundary the video path reads one maze row into a shadow
// register and then publishes it on row_buf. The generator is served only when
// the video path has nothing to do.
module maze_row_fetch_arbiter #(
   parameter int MAX_W = 20,
   parameter int MAX_H = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             line_start,
   input  logic [4:0]       maze_width,
   input  logic [4:0]       maze_height,
   input  logic [2:0]       tile_shift,
   input  logic             gen_req,
   input  logic             gen_we,
   input  logic [9:0]       gen_addr,
   input  logic             gen_wdata,
   output logic             gen_gnt,
   output logic             gen_rdata,
   output logic [9:0]       mem_addr,
   output logic             mem_we,
   output logic             mem_wdata,
   input  logic             mem_rdata,
   output logic [MAX_W-1:0] row_buf,
   output logic             row_valid,
   output logic             fetch_busy,
   output logic             overrun,
   output logic             cfg_err
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   localparam logic [5:0] MaxW6 = 6'(MAX_W);
   localparam logic [5:0] MaxH6 = 6'(MAX_H);

   state_t           state_q, state_d;
   logic [9:0]       lc_q, lc_d;
   logic [4:0]       tr_q, tr_d;
   logic [4:0]       frow_q, frow_d;
   logic [4:0]       col_q, col_d;
   logic [MAX_W-1:0] shadow_q, shadow_d;
   logic [MAX_W-1:0] rowBuf_q, rowBuf_d;
   logic             rowValid_q, rowValid_d;
   logic             overrun_q, overrun_d;
   logic             genRdPend_q, genRdPend_d;
   logic             genRdata_q, genRdata_d;

   logic             cfgErr;
   logic [9:0]       tileMask;
   logic             rowBoundary;
   logic             busy;
   logic             fetchPending;
   logic             blankRow;
   logic [4:0]       lastCol;
   logic             capEn;
   logic [4:0]       capIdx;
   logic [9:0]       memAddr;
   logic             memWe;
   logic             memWdata;
   logic             gnt;

   // Decode the configuration and line events: a row boundary is the first line
   // of a tile, and it either launches a RAM fetch or blanks the row when the
   // maze has no row there (or the geometry is illegal).
   always_comb begin
      cfgErr       = (maze_width == 5'd0) || ({1'b0, maze_width} > MaxW6) ||
                     (maze_height == 5'd0) || ({1'b0, maze_height} > MaxH6);
      tileMask     = (10'd1 << tile_shift) - 10'd1;
      busy         = (state_q != IDLE);
      rowBoundary  = line_start && !frame_start && ((lc_q & tileMask) == 10'd0);
      fetchPending = rowBoundary && !busy && (tr_q < maze_height) && !cfgErr;
      blankRow     = rowBoundary && !busy && !fetchPending;
      lastCol      = maze_width - 5'd1;
   end

   // Fetch FSM and RAM port mux: the video fetch always wins over the generator,
   // the generator only gets the port in a quiet IDLE cycle, and a frame_start
   // abandons any fetch in flight without touching row_buf.
   always_comb begin
      state_d    = state_q;
      col_d      = col_q;
      frow_d     = frow_q;
      shadow_d   = shadow_q;
      rowBuf_d   = rowBuf_q;
      rowValid_d = 1'b0;
      memAddr    = 10'd0;
      memWe      = 1'b0;
      memWdata   = 1'b0;
      gnt        = 1'b0;
      capEn      = 1'b0;
      capIdx     = 5'd0;

      case (state_q)
         IDLE: begin
            if (fetchPending) begin
               state_d  = FETCH;
               col_d    = 5'd0;
               frow_d   = tr_q;
               shadow_d = '0;
            end else if (gen_req) begin
               gnt      = 1'b1;
               memAddr  = gen_addr;
               memWe    = gen_we;
               memWdata = gen_wdata;
            end
         end
         FETCH: begin
            memAddr = {frow_q, col_q};
            capEn   = (col_q != 5'd0);
            capIdx  = col_q - 5'd1;
            if (col_q >= lastCol) begin
               state_d = DRAIN;
            end else begin
               col_d = col_q + 5'd1;
            end
         end
         DRAIN: begin
            capEn      = 1'b1;
            capIdx     = lastCol;
            state_d    = IDLE;
            rowValid_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      for (int c = 0; c < MAX_W; c++) begin
         if (capEn && (capIdx == 5'(c))) begin
            shadow_d[c] = mem_rdata;
         end
      end

      if (state_q == DRAIN) begin
         rowBuf_d = shadow_d;
      end

      if (blankRow) begin
         rowBuf_d   = '0;
         rowValid_d = 1'b1;
      end

      if (frame_start) begin
         state_d    = IDLE;
         rowBuf_d   = rowBuf_q;
         rowValid_d = 1'b0;
      end
   end

   // Line/tile counters, the sticky overrun flag and the generator read-data
   // return path, which captures RAM data one cycle after a granted read.
   always_comb begin
      lc_d        = lc_q;
      tr_d        = tr_q;
      overrun_d   = overrun_q;
      genRdPend_d = gnt && !gen_we;
      genRdata_d  = genRdPend_q ? mem_rdata : genRdata_q;
      if (frame_start) begin
         lc_d      = 10'd0;
         tr_d      = 5'd0;
         overrun_d = 1'b0;
      end else if (line_start) begin
         lc_d = lc_q + 10'd1;
         if (rowBoundary) begin
            tr_d = tr_q + 5'd1;
         end
         if (busy) begin
            overrun_d = 1'b1;
         end
      end
   end

   // State register; reset drops everything back to an empty IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         lc_q        <= 10'd0;
         tr_q        <= 5'd0;
         frow_q      <= 5'd0;
         col_q       <= 5'd0;
         shadow_q    <= '0;
         rowBuf_q    <= '0;
         rowValid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         genRdPend_q <= 1'b0;
         genRdata_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         lc_q        <= lc_d;
         tr_q        <= tr_d;
         frow_q      <= frow_d;
         col_q       <= col_d;
         shadow_q    <= shadow_d;
         rowBuf_q    <= rowBuf_d;
         rowValid_q  <= rowValid_d;
         overrun_q   <= overrun_d;
         genRdPend_q <= genRdPend_d;
         genRdata_q  <= genRdata_d;
      end
   end

   // Output drive; the combinational outputs are forced quiet while reset is
   // held so nothing reaches the RAM or the generator during reset.
   always_comb begin
      gen_gnt    = gnt && !reset;
      mem_we     = memWe && !reset;
      mem_wdata  = memWdata && !reset;
      mem_addr   = reset ? 10'd0 : memAddr;
      cfg_err    = cfgErr && !reset;
      gen_rdata  = genRdata_q;
      row_buf    = rowBuf_q;
      row_valid  = rowValid_q;
      fetch_busy = busy;
      overrun    = overrun_q;
   end

endmodule

// File: tb/tb_maze_row_fetch_arbiter.sv
// Directed bench for maze_row_fetch_arbiter with a behavioural one-cycle-latency
// maze RAM that can be preloaded from the stimulus sequence.
module tb_maze_row_fetch_arbiter;

   logic        clk;
   logic        reset;
   logic        frame_start;
   logic        line_start;
   logic [4:0]  maze_width;
   logic [4:0]  maze_height;
   logic [2:0]  tile_shift;
   logic        gen_req;
   logic        gen_we;
   logic [9:0]  gen_addr;
   logic        gen_wdata;
   logic        gen_gnt;
   logic        gen_rdata;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic        mem_wdata;
   logic        mem_rdata;
   logic [19:0] row_buf;
   logic        row_valid;
   logic        fetch_busy;
   logic        overrun;
   logic        cfg_err;

   logic        preWe;
   logic [9:0]  preAddr;
   logic        preData;
   logic        ram [0:1023];

   int          checks;
   int          errors;
   int          rvSeen;
   logic [19:0] expRow [0:2];

   maze_row_fetch_arbiter #(.MAX_W(20), .MAX_H(20)) dut (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .line_start (line_start),
      .maze_width (maze_width),
      .maze_height(maze_height),
      .tile_shift (tile_shift),
      .gen_req    (gen_req),
      .gen_we     (gen_we),
      .gen_addr   (gen_addr),
      .gen_wdata  (gen_wdata),
      .gen_gnt    (gen_gnt),
      .gen_rdata  (gen_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .row_buf    (row_buf),
      .row_valid  (row_valid),
      .fetch_busy (fetch_busy),
      .overrun    (overrun),
      .cfg_err    (cfg_err)
   );

   // Free-running 100 MHz clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port RAM model with registered read data; preload port has priority.
   always @(posedge clk) begin
      if (preWe) begin
         ram[preAddr] <= preData;
      end else if (mem_we) begin
         ram[mem_addr] <= mem_wdata;
      end
      mem_rdata <= ram[mem_addr];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] addr, input logic data);
      preWe   = 1'b1;
      preAddr = addr;
      preData = data;
      step();
      preWe   = 1'b0;
   endtask

   task automatic pulseFrame();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
   endtask

   task automatic pulseLine();
      line_start = 1'b1;
      step();
      line_start = 1'b0;
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      rvSeen      = 0;
      expRow[0]   = 20'h0000D;
      expRow[1]   = 20'h00006;
      expRow[2]   = 20'h00003;
      reset       = 1'b1;
      frame_start = 1'b0;
      line_start  = 1'b0;
      maze_width  = 5'd4;
      maze_height = 5'd20;
      tile_shift  = 3'd0;
      gen_req     = 1'b0;
      gen_we      = 1'b0;
      gen_addr    = 10'd0;
      gen_wdata   = 1'b0;
      preWe       = 1'b0;
      preAddr     = 10'd0;
      preData     = 1'b0;
      repeat (2) step();

      // RAM image: row0 cols0..3 = 1,0,1,1; row1 = 0,1,1,0; row2 = 1,1,0,0
      for (int a = 0; a < 1024; a++) begin
         applyStimulus(10'(a), 1'b0);
      end
      applyStimulus(10'd0, 1'b1);
      applyStimulus(10'd2, 1'b1);
      applyStimulus(10'd3, 1'b1);
      applyStimulus(10'd33, 1'b1);
      applyStimulus(10'd34, 1'b1);
      applyStimulus(10'd64, 1'b1);
      applyStimulus(10'd65, 1'b1);

      // Reset state
      checkOutput("rst_row_buf", 32'(row_buf), 32'h0);
      checkOutput("rst_row_valid", 32'(row_valid), 32'h0);
      checkOutput("rst_busy", 32'(fetch_busy), 32'h0);
      checkOutput("rst_overrun", 32'(overrun), 32'h0);
      checkOutput("rst_gnt", 32'(gen_gnt), 32'h0);
      checkOutput("rst_mem_addr", 32'(mem_addr), 32'h0);
      checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
      reset = 1'b0;
      step();

      // Basic fetch of row 0, width 4
      pulseFrame();
      pulseLine();
      checkOutput("f0_busy", 32'(fetch_busy), 32'h1);
      checkOutput("f0_addr_col0", 32'(mem_addr), 32'h000);
      checkOutput("f0_we", 32'(mem_we), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         step();
         checkOutput("f0_row_valid", 32'(row_valid), 32'(k == 5));
      end
      checkOutput("f0_row_buf", 32'(row_buf), 32'h0000D);
      checkOutput("f0_busy_done", 32'(fetch_busy), 32'h0);
      step();
      checkOutput("f0_row_valid_pulse", 32'(row_valid), 32'h0);

      // Generator write held off by the row-1 fetch
      pulseLine();
      gen_req   = 1'b1;
      gen_we    = 1'b1;
      gen_addr  = 10'h062;
      gen_wdata = 1'b1;
      #1;
      checkOutput("g_gnt_fetch", 32'(gen_gnt), 32'h0);
      for (int k = 1; k <= 5; k++) begin
         step();
         checkOutput("g_gnt_wait", 32'(gen_gnt), 32'(k == 5));
         if (k == 1) begin
            checkOutput("g_fetch_addr", 32'(mem_addr), 32'h021);
         end
      end
      checkOutput("g_mem_we", 32'(mem_we), 32'h1);
      checkOutput("g_mem_addr", 32'(mem_addr), 32'h062);
      checkOutput("g_mem_wdata", 32'(mem_wdata), 32'h1);
      checkOutput("g_row_buf", 32'(row_buf), 32'h00006);
      checkOutput("g_row_valid", 32'(row_valid), 32'h1);
      step();
      gen_we = 1'b0;
      #1;
      checkOutput("g_rd_gnt", 32'(gen_gnt), 32'h1);
      checkOutput("g_rd_we", 32'(mem_we), 32'h0);
      checkOutput("g_rd_addr", 32'(mem_addr), 32'h062);
      step();
      gen_req  = 1'b0;
      gen_addr = 10'd0;
      #1;
      checkOutput("g_gnt_drop", 32'(gen_gnt), 32'h0);
      step();
      checkOutput("g_rdata", 32'(gen_rdata), 32'h1);

      // Tile height 4: fetches on lines 0, 4, 8 for rows 0, 1, 2
      tile_shift = 3'd2;
      pulseFrame();
      for (int l = 0; l <= 8; l++) begin
         pulseLine();
         checkOutput("t_busy", 32'(fetch_busy), 32'((l % 4) == 0));
         if ((l % 4) == 0) begin
            checkOutput("t_row_addr", 32'(mem_addr), 32'((l / 4) * 32));
         end
         repeat (5) step();
         checkOutput("t_row_valid", 32'(row_valid), 32'((l % 4) == 0));
         if ((l % 4) == 0) begin
            checkOutput("t_row_buf", 32'(row_buf), 32'(expRow[l / 4]));
         end
         step();
      end

      // Height 2: third row boundary blanks the row without RAM reads
      tile_shift  = 3'd0;
      maze_height = 5'd2;
      pulseFrame();
      pulseLine();
      repeat (6) step();
      pulseLine();
      repeat (6) step();
      checkOutput("h_row1_buf", 32'(row_buf), 32'h00006);
      pulseLine();
      checkOutput("h_busy", 32'(fetch_busy), 32'h0);
      checkOutput("h_row_valid", 32'(row_valid), 32'h1);
      checkOutput("h_row_buf", 32'(row_buf), 32'h0);
      checkOutput("h_mem_addr", 32'(mem_addr), 32'h0);
      step();
      checkOutput("h_row_valid_pulse", 32'(row_valid), 32'h0);

      // Illegal geometry
      maze_height = 5'd20;
      maze_width  = 5'd0;
      #1;
      checkOutput("c_width0", 32'(cfg_err), 32'h1);
      maze_width = 5'd21;
      #1;
      checkOutput("c_width21", 32'(cfg_err), 32'h1);
      maze_width  = 5'd4;
      maze_height = 5'd0;
      #1;
      checkOutput("c_height0", 32'(cfg_err), 32'h1);
      maze_height = 5'd20;
      #1;
      checkOutput("c_legal", 32'(cfg_err), 32'h0);

      // Overrun: width 20, next line 10 cycles later
      maze_width = 5'd20;
      pulseFrame();
      pulseLine();
      checkOutput("o_overrun_clear", 32'(overrun), 32'h0);
      checkOutput("o_busy", 32'(fetch_busy), 32'h1);
      repeat (9) step();
      pulseLine();
      checkOutput("o_overrun_set", 32'(overrun), 32'h1);
      checkOutput("o_busy_still", 32'(fetch_busy), 32'h1);
      repeat (15) step();
      checkOutput("o_busy_done", 32'(fetch_busy), 32'h0);
      checkOutput("o_overrun_held", 32'(overrun), 32'h1);
      pulseFrame();
      checkOutput("o_overrun_frame", 32'(overrun), 32'h0);

      // Reset in the middle of a fetch
      maze_width = 5'd4;
      pulseFrame();
      pulseLine();
      repeat (6) step();
      checkOutput("r_row_buf_before", 32'(row_buf), 32'h0000D);
      pulseLine();
      step();
      #2;
      reset = 1'b1;
      #1;
      checkOutput("r_row_buf", 32'(row_buf), 32'h0);
      checkOutput("r_busy", 32'(fetch_busy), 32'h0);
      checkOutput("r_mem_addr", 32'(mem_addr), 32'h0);
      checkOutput("r_row_valid", 32'(row_valid), 32'h0);
      step();
      reset = 1'b0;
      repeat (8) begin
         step();
         rvSeen += int'(row_valid);
      end
      checkOutput("r_no_row_valid", 32'(rvSeen), 32'h0);
      checkOutput("r_row_buf_after", 32'(row_buf), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
